// File: rtl/grid_step_env_if.sv
// Action/result handshake bundle for the grid step environment.
// master = agent side (offers actions, consumes results); slave = environment.
interface grid_step_env_if #(
  parameter int COORD_W = 4
);
  logic               act_valid;
  logic               act_ready;
  logic [1:0]         act;
  logic               res_valid;
  logic               res_ready;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic [7:0]         reward;
  logic               done;
  logic               timeout;

  modport master (
    output act_valid, act, res_ready,
    input  act_ready, res_valid, cur_x, cur_y,
    input  reward, done, timeout
  );

  modport slave (
    input  act_valid, act, res_ready,
    output act_ready, res_valid, cur_x, cur_y,
    output reward, done, timeout
  );
endinterface

// File: rtl/grid_step_env.sv
// Q-learning grid environment: holds the agent tile, applies one move per
// handshake. Ports: clk/rst, start + start/goal coords, bus (slave), counters.
module grid_step_env #(
  parameter int              MAP_LEN   = 3,
  parameter int              COORD_W   = 4,
  parameter int              MAX_STEPS = 16,
  parameter logic signed [7:0] R_STEP  = -8'sd1,
  parameter logic signed [7:0] R_WALL  = -8'sd4,
  parameter logic signed [7:0] R_GOAL  = 8'sd10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic [COORD_W-1:0] goal_x,
  input  logic [COORD_W-1:0] goal_y,
  grid_step_env_if.slave     bus,
  output logic [7:0]         step_cnt,
  output logic [15:0]        ep_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] LEN = COORD_W'(MAP_LEN);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [7:0]         rew_q, rew_d;
  logic               done_q, done_d;
  logic               to_q, to_d;
  logic [7:0]         step_q, step_d;
  logic [15:0]        ep_q, ep_d;

  logic               wall;
  logic [COORD_W-1:0] nx, ny;
  logic [7:0]         step_n;
  logic               hit;

  function automatic logic [COORD_W-1:0] clamp(
    input logic [COORD_W-1:0] v
  );
    if (v == '0)      return ONE;
    else if (v > LEN) return LEN;
    else              return v;
  endfunction

  // Edge test precedes inc/dec so the coordinate never wraps.
  always_comb begin
    wall = 1'b0;
    nx   = cx_q;
    ny   = cy_q;
    unique case (bus.act)
      2'd0: if (cy_q == ONE) wall = 1'b1; else ny = cy_q - ONE;
      2'd1: if (cy_q == LEN) wall = 1'b1; else ny = cy_q + ONE;
      2'd2: if (cx_q == ONE) wall = 1'b1; else nx = cx_q - ONE;
      2'd3: if (cx_q == LEN) wall = 1'b1; else nx = cx_q + ONE;
      default: wall = 1'b1;
    endcase
    hit    = !wall && (nx == gx_q) && (ny == gy_q);
    step_n = step_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    rew_d   = rew_q;
    done_d  = done_q;
    to_d    = to_q;
    step_d  = step_q;
    ep_d    = ep_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cx_d    = clamp(start_x);
        cy_d    = clamp(start_y);
        gx_d    = goal_x;
        gy_d    = goal_y;
        rew_d   = '0;
        step_d  = '0;
        done_d  = 1'b0;
        to_d    = 1'b0;
      end
      RUN: if (bus.act_valid) begin
        state_d = RESP;
        step_d  = step_n;
        if (!wall) begin
          cx_d = nx;
          cy_d = ny;
        end
        rew_d  = wall ? R_WALL : (hit ? R_GOAL : R_STEP);
        done_d = hit || (step_n == 8'(MAX_STEPS));
        to_d   = !hit && (step_n == 8'(MAX_STEPS));
      end
      RESP: if (bus.res_ready) begin
        state_d = done_q ? IDLE : RUN;
        if (done_q) ep_d = ep_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= ONE;
      cy_q    <= ONE;
      gx_q    <= ONE;
      gy_q    <= ONE;
      rew_q   <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      step_q  <= '0;
      ep_q    <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      rew_q   <= rew_d;
      done_q  <= done_d;
      to_q    <= to_d;
      step_q  <= step_d;
      ep_q    <= ep_d;
    end
  end

  assign bus.act_ready = (state_q == RUN);
  assign bus.res_valid = (state_q == RESP);
  assign bus.cur_x     = cx_q;
  assign bus.cur_y     = cy_q;
  assign bus.reward    = rew_q;
  assign bus.done      = done_q;
  assign bus.timeout   = to_q;
  assign step_cnt      = step_q;
  assign ep_cnt        = ep_q;

endmodule
